trade_uart_tx: RTL and testbench

- Transmit end of the trade stream leaving the matching engine. Captures each executed trade (trade price, best bid, best ask) into a small FIFO and serialises it off-board as a framed 8N1 UART packet.
- Sits beside the controller FSM and trade counter. It consumes the same match and halt signals, so a host PC can log every trade the board reports.

---
 rtl/trade_uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_trade_uart_tx.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trade_uart_tx.sv
// Trade record UART transmitter: captures matched trades into a FIFO and sends each as a
// 5-byte 8N1 frame (sync, price, bid, ask, xor checksum).
module trade_uart_tx #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                         clk_50,
   input  logic                         reset_n,
   input  logic                         match_signal,
   input  logic                         halt_signal,
   input  logic [7:0]                   trade_price,
   input  logic [7:0]                   best_bid,
   input  logic [7:0]                   best_ask,
   output logic                         uart_txd,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow,
   output logic [7:0]                   frames_sent
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

   state_e        state_q, state_d;
   logic          match_q;
   logic [23:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          overflow_q;
   logic [23:0]   frame_q, frame_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    byte_idx_q, byte_idx_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [7:0]    frames_q, frames_d;
   logic          txd_q, txd_d;

   logic push_req, push, pop, drop, bit_done;

   function automatic logic [7:0] byte_sel(input logic [23:0] rec, input logic [2:0] idx);
      case (idx)
         3'd0:    byte_sel = 8'hA5;
         3'd1:    byte_sel = rec[23:16];
         3'd2:    byte_sel = rec[15:8];
         3'd3:    byte_sel = rec[7:0];
         default: byte_sel = rec[23:16] ^ rec[15:8] ^ rec[7:0];
      endcase
   endfunction

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_req = match_signal & ~match_q & ~halt_signal;
   assign pop      = (state_q == StIdle) && (count_q != '0);
   assign push     = push_req && ((count_q < DEPTH_C) || pop);
   assign drop     = push_req && !push;
   assign bit_done = (clk_cnt_q == BIT_LAST);

   always_ff @(posedge clk_50) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {trade_price, best_bid, best_ask};
      end
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         match_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         match_q <= match_signal;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
         if (drop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         frame_q    <= '0;
         shift_q    <= '0;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         clk_cnt_q  <= '0;
         frames_q   <= '0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         clk_cnt_q  <= clk_cnt_d;
         frames_q   <= frames_d;
         txd_q      <= txd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      shift_d    = shift_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      clk_cnt_d  = clk_cnt_q;
      frames_d   = frames_q;
      txd_d      = 1'b1;

      case (state_q)
         StIdle: begin
            if (pop) begin
               frame_d    = mem_q[rd_ptr_q];
               byte_idx_d = '0;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            shift_d   = byte_sel(frame_q, byte_idx_q);
            clk_cnt_d = '0;
            state_d   = StStart;
         end
         StStart: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = StData;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         StData: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) state_d = StStop;
               else                   bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               // Next byte goes straight into its start bit, no idle gap inside a frame.
               if (byte_idx_q != 3'd4) begin
                  byte_idx_d = byte_idx_q + 1'b1;
                  shift_d    = byte_sel(frame_q, 3'(byte_idx_q + 3'd1));
                  state_d    = StStart;
               end else begin
                  frames_d = frames_q + 1'b1;
                  state_d  = StIdle;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      case (state_d)
         StStart: txd_d = 1'b0;
         StData:  txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   assign uart_txd    = txd_q;
   assign busy        = (state_q != StIdle);
   assign fifo_count  = count_q;
   assign overflow    = overflow_q;
   assign frames_sent = frames_q;

endmodule

// File: tb/tb_trade_uart_tx.sv
// Directed bench for trade_uart_tx at 4 clocks per bit: framing, latency, overflow, halt,
// frame counter wrap and asynchronous reset in mid-frame.
module tb_trade_uart_tx;

   logic       clk_50;
   logic       reset_n;
   logic       match_signal;
   logic       halt_signal;
   logic [7:0] trade_price;
   logic [7:0] best_bid;
   logic [7:0] best_ask;
   logic       uart_txd;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;
   logic [7:0] frames_sent;

   int vectors;
   int miscompares;

   trade_uart_tx #(
      .CLK_HZ     (400),
      .BAUD       (100),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_50       (clk_50),
      .reset_n      (reset_n),
      .match_signal (match_signal),
      .halt_signal  (halt_signal),
      .trade_price  (trade_price),
      .best_bid     (best_bid),
      .best_ask     (best_ask),
      .uart_txd     (uart_txd),
      .busy         (busy),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .frames_sent  (frames_sent)
   );

   initial clk_50 = 1'b0;
   always #5 clk_50 = ~clk_50;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
      $fatal(1);
   end

   function automatic logic [39:0] exp_frame(input logic [7:0] p, input logic [7:0] b,
                                             input logic [7:0] a);
      exp_frame = {8'hA5, p, b, a, p ^ b ^ a};
   endfunction

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic apply_reset();
      reset_n      = 1'b0;
      match_signal = 1'b0;
      halt_signal  = 1'b0;
      trade_price  = 8'h00;
      best_bid     = 8'h00;
      best_ask     = 8'h00;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   // One-cycle match pulse; returns one cycle after the edge cycle.
   task automatic send_edge(input logic [7:0] p, input logic [7:0] b, input logic [7:0] a);
      trade_price  = p;
      best_bid     = b;
      best_ask     = a;
      match_signal = 1'b1;
      tick();
      match_signal = 1'b0;
   endtask

   // Ticks until txd is low; n = ticks taken, or -1 if the limit expires.
   task automatic wait_low(input int limit, output int n);
      bit found;
      found = (uart_txd === 1'b0);
      n = 0;
      while (!found && n < limit) begin
         tick();
         n++;
         found = (uart_txd === 1'b0);
      end
      if (!found) n = -1;
   endtask

   // Entered in the first cycle of a start bit; leaves in the middle of the stop bit.
   task automatic recv_byte(output logic [7:0] b, output bit ok);
      ok = 1'b1;
      b  = 8'h00;
      repeat (2) tick();
      if (uart_txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (4) tick();
         b[i] = uart_txd;
      end
      repeat (4) tick();
      if (uart_txd !== 1'b1) ok = 1'b0;
   endtask

   task automatic recv_frame(output logic [39:0] f, output bit ok);
      logic [7:0] b;
      bit         bok;
      int         n;
      ok = 1'b1;
      f  = '0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            wait_low(8, n);
            if (n != 2) ok = 1'b0;
         end
         if (uart_txd === 1'b0) begin
            recv_byte(b, bok);
            if (!bok) ok = 1'b0;
         end else begin
            b  = 8'h00;
            ok = 1'b0;
         end
         f = {f[31:0], b};
      end
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if ({uart_txd, busy, fifo_count, overflow, frames_sent} !== {1'b1, 1'b0, 3'd0, 1'b0, 8'd0}) begin
         miscompares++;
         $display("FAIL reset_state: txd=%b busy=%b cnt=%0d ovf=%b sent=%0d, required 1 0 0 0 0",
                  uart_txd, busy, fifo_count, overflow, frames_sent);
      end
   endtask

   task automatic test_single_trade();
      logic [39:0] f;
      bit          ok;
      int          n;
      apply_reset();
      trade_price  = 8'h32;
      best_bid     = 8'h34;
      best_ask     = 8'h30;
      match_signal = 1'b1;
      tick();
      vectors++;
      if (fifo_count !== 3'd1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_queued: cnt=%0d busy=%b, required 1 0", fifo_count, busy);
      end
      tick();
      vectors++;
      if (busy !== 1'b1 || uart_txd !== 1'b1 || fifo_count !== 3'd0) begin
         miscompares++;
         $display("FAIL single_load: busy=%b txd=%b cnt=%0d, required 1 1 0", busy, uart_txd, fifo_count);
      end
      match_signal = 1'b0;
      trade_price  = 8'hFF;
      best_bid     = 8'hEE;
      best_ask     = 8'hDD;
      tick();
      vectors++;
      if (uart_txd !== 1'b0) begin
         miscompares++;
         $display("FAIL single_start_latency: txd=%b 3 cycles after edge, required 0", uart_txd);
      end
      recv_frame(f, ok);
      vectors++;
      if (!ok || f !== 40'hA5_32_34_30_36) begin
         miscompares++;
         $display("FAIL single_frame: got %h framing_ok=%b, required a532343036 framing_ok=1", f, ok);
      end
      repeat (2) tick();
      vectors++;
      if (busy !== 1'b0 || frames_sent !== 8'd1 || overflow !== 1'b0 || fifo_count !== 3'd0) begin
         miscompares++;
         $display("FAIL single_after: busy=%b sent=%0d ovf=%b cnt=%0d, required 0 1 0 0",
                  busy, frames_sent, overflow, fifo_count);
      end
      wait_low(30, n);
      vectors++;
      if (n != -1) begin
         miscompares++;
         $display("FAIL single_no_extra: start bit after %0d cycles, required none", n);
      end
   endtask

   task automatic test_burst_overflow();
      apply_reset();
      best_bid = 8'h01;
      best_ask = 8'h02;
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               trade_price  = 8'(8'h10 + k);
               match_signal = 1'b1;
               tick();
               match_signal = 1'b0;
               tick();
            end
            vectors++;
            if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
               miscompares++;
               $display("FAIL burst_fill: ovf=%b cnt=%0d, required 1 4", overflow, fifo_count);
            end
         end
         begin
            logic [39:0] f;
            bit          ok;
            int          n;
            wait_low(20, n);
            vectors++;
            if (n != 3) begin
               miscompares++;
               $display("FAIL burst_first_latency: %0d cycles, required 3", n);
            end
            for (int k = 0; k < 5; k++) begin
               if (k > 0) begin
                  wait_low(12, n);
                  vectors++;
                  if (n != 4) begin
                     miscompares++;
                     $display("FAIL burst_gap%0d: %0d cycles to start, required 4", k, n);
                  end
               end
               recv_frame(f, ok);
               vectors++;
               if (!ok || f !== exp_frame(8'(8'h10 + k), 8'h01, 8'h02)) begin
                  miscompares++;
                  $display("FAIL burst_frame%0d: got %h ok=%b, required %h ok=1",
                           k, f, ok, exp_frame(8'(8'h10 + k), 8'h01, 8'h02));
               end
            end
         end
      join
      begin
         int n;
         repeat (2) tick();
         vectors++;
         if (overflow !== 1'b1 || frames_sent !== 8'd5 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_end: ovf=%b sent=%0d cnt=%0d busy=%b, required 1 5 0 0",
                     overflow, frames_sent, fifo_count, busy);
         end
         wait_low(60, n);
         vectors++;
         if (n != -1) begin
            miscompares++;
            $display("FAIL burst_dropped_sent: sixth frame started after %0d cycles, required none", n);
         end
      end
   endtask

   task automatic test_halt();
      logic [39:0] f;
      bit          ok;
      int          n;
      apply_reset();
      halt_signal = 1'b1;
      send_edge(8'h77, 8'h78, 8'h79);
      repeat (3) tick();
      vectors++;
      if (fifo_count !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_gate: cnt=%0d busy=%b ovf=%b, required 0 0 0", fifo_count, busy, overflow);
      end
      wait_low(30, n);
      vectors++;
      if (n != -1) begin
         miscompares++;
         $display("FAIL halt_no_frame: start bit after %0d cycles, required none", n);
      end
      halt_signal = 1'b0;
      send_edge(8'h5A, 8'h11, 8'h22);
      wait_low(10, n);
      vectors++;
      if (n != 2) begin
         miscompares++;
         $display("FAIL halt_release_latency: %0d cycles, required 2", n);
      end
      recv_frame(f, ok);
      vectors++;
      if (!ok || f !== 40'hA5_5A_11_22_69) begin
         miscompares++;
         $display("FAIL halt_release_frame: got %h ok=%b, required a55a112269 ok=1", f, ok);
      end
      repeat (2) tick();
      vectors++;
      if (frames_sent !== 8'd1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_count: sent=%0d busy=%b, required 1 0", frames_sent, busy);
      end
   endtask

   // Continues from the halt test state (one frame already counted).
   task automatic test_reset_mid_frame();
      logic [7:0]  b;
      logic [39:0] f;
      bit          ok;
      int          n;
      send_edge(8'h3C, 8'hC3, 8'h99);
      tick();
      send_edge(8'h3D, 8'hC4, 8'h9A);
      vectors++;
      if (fifo_count !== 3'd1) begin
         miscompares++;
         $display("FAIL midreset_queued: cnt=%0d, required 1", fifo_count);
      end
      wait_low(10, n);
      recv_byte(b, ok);
      vectors++;
      if (n != 0 || !ok || b !== 8'hA5) begin
         miscompares++;
         $display("FAIL midreset_byte0: got %h ok=%b wait=%0d, required a5 1 0", b, ok, n);
      end
      wait_low(8, n);
      recv_byte(b, ok);
      vectors++;
      if (n != 2 || !ok || b !== 8'h3C) begin
         miscompares++;
         $display("FAIL midreset_byte1: got %h ok=%b wait=%0d, required 3c 1 2", b, ok, n);
      end
      wait_low(8, n);
      repeat (14) tick();
      vectors++;
      if (n != 2 || uart_txd !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_in_byte2: txd=%b busy=%b wait=%0d, required 0 1 2", uart_txd, busy, n);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({uart_txd, busy, fifo_count, overflow, frames_sent} !== {1'b1, 1'b0, 3'd0, 1'b0, 8'd0}) begin
         miscompares++;
         $display("FAIL midreset_async: txd=%b busy=%b cnt=%0d ovf=%b sent=%0d, required 1 0 0 0 0",
                  uart_txd, busy, fifo_count, overflow, frames_sent);
      end
      tick();
      reset_n = 1'b1;
      tick();
      wait_low(30, n);
      vectors++;
      if (n != -1) begin
         miscompares++;
         $display("FAIL midreset_no_resume: start bit after %0d cycles, required none", n);
      end
      send_edge(8'h42, 8'h43, 8'h44);
      wait_low(10, n);
      recv_frame(f, ok);
      vectors++;
      if (n != 2 || !ok || f !== 40'hA5_42_43_44_45) begin
         miscompares++;
         $display("FAIL midreset_next_frame: got %h ok=%b wait=%0d, required a542434445 1 2", f, ok, n);
      end
      repeat (2) tick();
      vectors++;
      if (frames_sent !== 8'd1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_count: sent=%0d busy=%b, required 1 0", frames_sent, busy);
      end
   endtask

   task automatic test_wrap();
      logic [39:0] f;
      bit          ok;
      int          n;
      int          cnt;
      int          timeouts;
      apply_reset();
      timeouts = 0;
      for (int i = 1; i <= 257; i++) begin
         send_edge(8'h55, 8'h55, 8'h55);
         wait_low(10, n);
         if (n != 2) timeouts++;
         if (i == 1) begin
            recv_frame(f, ok);
            vectors++;
            if (!ok || f !== 40'hA5_55_55_55_55) begin
               miscompares++;
               $display("FAIL wrap_first_frame: got %h ok=%b, required a555555555 ok=1", f, ok);
            end
         end
         cnt = 0;
         while (busy !== 1'b0 && cnt < 260) begin
            tick();
            cnt++;
         end
         if (busy !== 1'b0) timeouts++;
         if (i == 255) begin
            vectors++;
            if (frames_sent !== 8'hFF) begin
               miscompares++;
               $display("FAIL wrap_255: sent=%h, required ff", frames_sent);
            end
         end
         if (i == 256) begin
            vectors++;
            if (frames_sent !== 8'h00) begin
               miscompares++;
               $display("FAIL wrap_256: sent=%h, required 00", frames_sent);
            end
         end
         if (i == 257) begin
            vectors++;
            if (frames_sent !== 8'h01) begin
               miscompares++;
               $display("FAIL wrap_257: sent=%h, required 01", frames_sent);
            end
         end
      end
      vectors++;
      if (timeouts != 0) begin
         miscompares++;
         $display("FAIL wrap_timing: %0d frames late or missing, required 0", timeouts);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single_trade();
      test_burst_overflow();
      test_halt();
      test_reset_mid_frame();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
